uart_int_ctrl: RTL
==================

Name: uart_int_ctrl

Overview:
Interrupt controller and auto-flow scheduler for the UART peripheral. It collects the event sources from the RX/TX datapath and the register block, arbitrates them by fixed 16550 priority into the IIR code and the INT line, and runs the character-timeout counter. It also drives RTS and gates TX start from CTS when auto-flow is enabled. It sits between the control-register block and the UART_TX/UART_RX/BAUD_GEN datapath.

Parameters:
FIFO_DEPTH, 16, RX FIFO depth in bytes.
LVL_W, 5, width of FIFO level/trigger buses; must satisfy 2^LVL_W > FIFO_DEPTH.
TO_W, 10, timeout counter width; must hold 768, i.e. 12 bits x 64 ticks.

Ports:
CLK  in  1  system clock
RESETn  in  1  asynchronous active-low reset
IER  in  4  [0]ERBI [1]ETBEI [2]ELSI [3]EDSSI
LCR  in  4  [1:0]WLS [2]STB [3]PEN
AFE  in  1  auto-flow enable (MCR[5])
MCR_RTS  in  1  software RTS request (MCR[1])
BAUD_TICK  in  1  one-cycle 16x-oversample strobe from BAUD_GEN
RX_LEVEL  in  LVL_W  RX FIFO occupancy
RX_TRIG  in  LVL_W  RX trigger level decoded from FCR (1/4/8/14)
RX_PUSH  in  1  RX FIFO write strobe
RBR_RD  in  1  RBR read strobe
LSR_ERR  in  1  OR of OE/PE/FE/BI sticky bits
LSR_RD  in  1  LSR read strobe
THR_EMPTY  in  1  TX FIFO/THR empty
THR_WR  in  1  THR write strobe
MSR_DELTA  in  1  OR of MSR delta bits
MSR_RD  in  1  MSR read strobe
IIR_RD  in  1  IIR read strobe
CTS_N  in  1  asynchronous clear-to-send pin (active low)
IIR  out  4  interrupt identification code
INT  out  1  interrupt request, active high
RTS_N  out  1  request-to-send pin (active low)
TX_ALLOW  out  1  TX may start the next character

Behaviour:
- Reset values: IIR=4'b0001, INT=0, RTS_N=1, TX_ALLOW=0. Timeout counter=0. All pending flags=0. CTS synchronizer flops=1.
- Source pending conditions:
  - RLS: LSR_ERR & ELSI.
  - RDA: ERBI & (RX_LEVEL >= RX_TRIG).
  - CTI: ERBI & timeout flag.
  - THRE: registered flag.
  - MSI: MSR_DELTA & EDSSI.
- THRE flag:
  - Set when THR_EMPTY rises while ETBEI=1, or when ETBEI rises while THR_EMPTY=1.
  - Cleared by THR_WR, by ETBEI=0, or by IIR_RD when the IIR value presented in that cycle is 4'b0010.
  - If set and clear occur in the same cycle, clear wins.
- Priority, highest first, with IIR code: RLS 4'b0110, RDA 4'b0100, CTI 4'b1100, THRE 4'b0010, MSI 4'b0000, none 4'b0001.
- IIR and INT are registered and update one cycle after a source changes. INT = ~IIR[0].
- Timeout counter:
  - Reset to 0 on RX_PUSH, RBR_RD, or RX_LEVEL==0.
  - Otherwise increments on each BAUD_TICK and saturates at the limit.
  - Limit = 64 x (1 + (5+WLS) + PEN + (1+STB)), i.e. 4 character times of 16 ticks per bit. Range 448..768.
  - Timeout flag is set when the counter reaches the limit and cleared with the counter.
  - An LCR change mid-count recomputes the limit immediately; a count already at or above the new limit sets the flag.
- RTS:
  - AFE=0: RTS_N = ~MCR_RTS, registered.
  - AFE=1 and MCR_RTS=1: RTS_N goes to 1 when RX_LEVEL >= RX_TRIG and returns to 0 when RX_LEVEL < RX_TRIG.
  - MCR_RTS=0 forces RTS_N=1.
- CTS: CTS_N passes through a 2-flop synchronizer. TX_ALLOW = AFE ? ~cts_sync : 1, registered. TX_ALLOW therefore reaches 1 on the second cycle after reset release when AFE=0. UART_TX samples TX_ALLOW only at character start; a mid-character change does not abort transmission.
- Reset asserted mid-operation returns every output and flag to its reset value asynchronously.

Decomposition:
- Shared package uart_pkg holds:
  - IIR code constants (IIR_NONE, IIR_RLS, IIR_RDA, IIR_CTI, IIR_THRE, IIR_MSI).
  - IER bit indices.
  - LCR field indices.
  - TO_TICKS_PER_BIT=64.
- One sub-module, uart_char_timeout: timeout counter plus limit computation.
- Priority encoder, THRE flag and flow control stay in the top-level module.

Test Plan:
- Set IER=4'b0001, RX_TRIG=8; push 8 bytes -> IIR=4'b0100 and INT=1 one cycle after RX_LEVEL=8. Read RBR once (level 7) -> IIR=4'b0001.
- Set IER=4'b0001, LCR=4'b0011 (8N1, limit 640); push 1 byte, then send 640 BAUD_TICKs -> IIR=4'b1100. RBR_RD -> IIR=4'b0001 and counter back to 0.
- Set IER=4'b0010 with THR_EMPTY=1 -> IIR=4'b0010. IIR_RD -> IIR=4'b0001. THR_WR then THR_EMPTY rising -> IIR=4'b0010 again.
- Set IER=4'b1111 and assert RLS, RDA, THRE and MSI together -> IIR=4'b0110. Clear LSR_ERR -> 4'b0100. Drain RX -> 4'b0010. IIR_RD -> 4'b0000.
- Set AFE=1, MCR_RTS=1, RX_TRIG=14; fill to 14 -> RTS_N=1. Drain to 13 -> RTS_N=0. Drive CTS_N=1 -> TX_ALLOW=0 exactly 3 cycles later.
- Assert RESETn low mid-timeout with INT=1 -> IIR=4'b0001, INT=0 and RTS_N=1 immediately. The counter restarts from 0 after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART interrupt/flow-control slice: IIR codes,
// register field positions and character-timeout scaling.
package uart_pkg;

   // IER bit positions
   localparam int unsigned IER_ERBI  = 0;
   localparam int unsigned IER_ETBEI = 1;
   localparam int unsigned IER_ELSI  = 2;
   localparam int unsigned IER_EDSSI = 3;

   // LCR field positions
   localparam int unsigned LCR_WLS_LSB = 0;
   localparam int unsigned LCR_WLS_MSB = 1;
   localparam int unsigned LCR_STB     = 2;
   localparam int unsigned LCR_PEN     = 3;

   // 4 character times at 16 oversample ticks per bit
   localparam int unsigned TO_TICKS_PER_BIT = 64;
   localparam int unsigned TO_TICK_SHIFT    = $clog2(TO_TICKS_PER_BIT);

   // Interrupt identification codes
   typedef enum logic [3:0] {
      IIR_MSI  = 4'b0000,
      IIR_NONE = 4'b0001,
      IIR_THRE = 4'b0010,
      IIR_RDA  = 4'b0100,
      IIR_RLS  = 4'b0110,
      IIR_CTI  = 4'b1100
   } iir_e;

   // Bits per character frame: start + (5+WLS) data + parity + (1+STB) stop
   function automatic logic [3:0] char_bits(input logic [3:0] lcr);
      return 4'd7
           + {2'b00, lcr[LCR_WLS_MSB:LCR_WLS_LSB]}
           + {3'b000, lcr[LCR_PEN]}
           + {3'b000, lcr[LCR_STB]};
   endfunction

endpackage

// File: rtl/uart_char_timeout.sv
// Character-timeout counter: counts baud ticks while the RX FIFO holds data
// and nothing is pushed or read; flags once 4 character times have elapsed.
module uart_char_timeout
   import uart_pkg::*;
#(
   parameter int unsigned TO_W = 10
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] lcr_i,
   input  logic       baud_tick_i,
   input  logic       clr_i,
   output logic       to_flag_o
);

   logic [TO_W-1:0] limit;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            flag_q, flag_d;

   // Limit follows LCR combinationally so a mid-count change takes effect at once
   always_comb begin
      limit = TO_W'(char_bits(lcr_i)) << TO_TICK_SHIFT;
   end

   // Next count and flag; the flag is evaluated on the next count so it rises
   // on the same edge the counter reaches (or already exceeds) the limit
   always_comb begin
      cnt_d  = cnt_q;
      flag_d = flag_q;
      if (clr_i) begin
         cnt_d  = '0;
         flag_d = 1'b0;
      end else begin
         if (baud_tick_i && (cnt_q < limit)) begin
            cnt_d = cnt_q + TO_W'(1);
         end
         flag_d = flag_q | (cnt_d >= limit);
      end
   end

   // Counter and flag state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign to_flag_o = flag_q;

endmodule

// File: rtl/uart_int_ctrl.sv
// UART interrupt controller: 16550 priority encoding into IIR/INT, THRE
// event flag, character timeout, RTS generation and CTS-gated TX start.
module uart_int_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned LVL_W      = 5,
   parameter int unsigned TO_W       = 10
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic [3:0]       IER,
   input  logic [3:0]       LCR,
   input  logic             AFE,
   input  logic             MCR_RTS,
   input  logic             BAUD_TICK,
   input  logic [LVL_W-1:0] RX_LEVEL,
   input  logic [LVL_W-1:0] RX_TRIG,
   input  logic             RX_PUSH,
   input  logic             RBR_RD,
   input  logic             LSR_ERR,
   input  logic             LSR_RD,
   input  logic             THR_EMPTY,
   input  logic             THR_WR,
   input  logic             MSR_DELTA,
   input  logic             MSR_RD,
   input  logic             IIR_RD,
   input  logic             CTS_N,
   output logic [3:0]       IIR,
   output logic             INT,
   output logic             RTS_N,
   output logic             TX_ALLOW
);

   if ((2 ** LVL_W) <= FIFO_DEPTH) begin : g_bad_lvl_w
      $error("LVL_W too narrow for FIFO_DEPTH");
   end
   if ((2 ** TO_W) <= 768) begin : g_bad_to_w
      $error("TO_W too narrow for the maximum timeout limit");
   end

   // LSR/MSR sticky bits are cleared in the register block; the read strobes
   // only matter there, since LSR_ERR/MSR_DELTA drop when the bits clear.
   logic unused_rd_strobes;
   assign unused_rd_strobes = LSR_RD ^ MSR_RD;

   logic rx_at_trig;
   logic to_flag;
   logic rls, rda, cti, msi;
   logic thre_q, thre_d;
   logic thr_empty_q, etbei_q;
   logic thre_set, thre_clr;
   iir_e iir_q, iir_d;
   logic int_q;
   logic cts_meta_q, cts_sync_q;
   logic tx_allow_q, tx_allow_d;
   logic rts_n_q, rts_n_d;

   assign rx_at_trig = (RX_LEVEL >= RX_TRIG);

   uart_char_timeout #(
      .TO_W(TO_W)
   ) u_to (
      .clk_i       (CLK),
      .rst_ni      (RESETn),
      .lcr_i       (LCR),
      .baud_tick_i (BAUD_TICK),
      .clr_i       (RX_PUSH | RBR_RD | (RX_LEVEL == '0)),
      .to_flag_o   (to_flag)
   );

   // Source pending conditions
   always_comb begin
      rls = LSR_ERR & IER[IER_ELSI];
      rda = IER[IER_ERBI] & rx_at_trig;
      cti = IER[IER_ERBI] & to_flag;
      msi = MSR_DELTA & IER[IER_EDSSI];
   end

   // THRE flag: edge-triggered set, clear has priority over set
   always_comb begin
      thre_set = IER[IER_ETBEI] & THR_EMPTY & (~thr_empty_q | ~etbei_q);
      thre_clr = THR_WR | ~IER[IER_ETBEI] | (IIR_RD & (iir_q == IIR_THRE));
      thre_d   = thre_q;
      if (thre_clr) begin
         thre_d = 1'b0;
      end else if (thre_set) begin
         thre_d = 1'b1;
      end
   end

   // Fixed priority encoder into the next IIR code
   always_comb begin
      iir_d = IIR_NONE;
      if (rls) begin
         iir_d = IIR_RLS;
      end else if (rda) begin
         iir_d = IIR_RDA;
      end else if (cti) begin
         iir_d = IIR_CTI;
      end else if (thre_q) begin
         iir_d = IIR_THRE;
      end else if (msi) begin
         iir_d = IIR_MSI;
      end
   end

   // Interrupt state: THRE flag, its edge-detect history, IIR and INT
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         thre_q      <= 1'b0;
         thr_empty_q <= 1'b0;
         etbei_q     <= 1'b0;
         iir_q       <= IIR_NONE;
         int_q       <= 1'b0;
      end else begin
         thre_q      <= thre_d;
         thr_empty_q <= THR_EMPTY;
         etbei_q     <= IER[IER_ETBEI];
         iir_q       <= iir_d;
         int_q       <= ~iir_d[0];
      end
   end

   // Next RTS/TX_ALLOW values from auto-flow mode
   always_comb begin
      if (!MCR_RTS) begin
         rts_n_d = 1'b1;
      end else if (AFE) begin
         rts_n_d = rx_at_trig;
      end else begin
         rts_n_d = 1'b0;
      end
      tx_allow_d = AFE ? ~cts_sync_q : 1'b1;
   end

   // Flow control: CTS synchronizer, registered RTS_N and TX_ALLOW
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cts_meta_q <= 1'b1;
         cts_sync_q <= 1'b1;
         tx_allow_q <= 1'b0;
         rts_n_q    <= 1'b1;
      end else begin
         cts_meta_q <= CTS_N;
         cts_sync_q <= cts_meta_q;
         tx_allow_q <= tx_allow_d;
         rts_n_q    <= rts_n_d;
      end
   end

   assign IIR      = iir_q;
   assign INT      = int_q;
   assign RTS_N    = rts_n_q;
   assign TX_ALLOW = tx_allow_q;

endmodule
